// File: rtl/alu_issue_stage.sv
// Issue register between MIPS decode and the ALU: decodes one instruction per accepted
// handshake into ALU operands/command plus writeback/memory flags, and counts illegal words.
module alu_issue_stage (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        instr,
   input  logic [31:0]        rs_data,
   input  logic [31:0]        rt_data,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [31:0] out_a,
   output logic signed [31:0] out_b,
   output logic [3:0]         out_cmd,
   output logic [4:0]         out_dest,
   output logic               out_we,
   output logic               out_mem_rd,
   output logic               out_mem_wr,
   output logic               out_illegal,
   output logic [7:0]         illegal_count
);

   localparam logic [3:0] CMD_ADD    = 4'd0;
   localparam logic [3:0] CMD_SUB    = 4'd2;
   localparam logic [3:0] CMD_AND    = 4'd4;
   localparam logic [3:0] CMD_OR     = 4'd5;
   localparam logic [3:0] CMD_NOR    = 4'd6;
   localparam logic [3:0] CMD_XOR    = 4'd7;
   localparam logic [3:0] CMD_LEFT   = 4'd8;
   localparam logic [3:0] CMD_SRIGHT = 4'd9;
   localparam logic [3:0] CMD_RIGHT  = 4'd10;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rt_idx;
   logic [4:0]  rd_idx;
   logic [31:0] shamt_z;
   logic [31:0] imm_s;
   logic [31:0] imm_z;
   logic [4:0]  unused_rs_idx;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign rt_idx        = instr[20:16];
   assign rd_idx        = instr[15:11];
   assign shamt_z       = {27'b0, instr[10:6]};
   assign imm_s         = {{16{instr[15]}}, instr[15:0]};
   assign imm_z         = {16'b0, instr[15:0]};
   assign unused_rs_idx = instr[25:21];

   logic [31:0] dec_a, dec_b;
   logic [3:0]  dec_cmd;
   logic [4:0]  dec_dest;
   logic        dec_we, dec_mem_rd, dec_mem_wr, dec_ill;

   always_comb begin
      dec_a      = rs_data;
      dec_b      = rt_data;
      dec_cmd    = CMD_ADD;
      dec_dest   = rt_idx;
      dec_we     = 1'b1;
      dec_mem_rd = 1'b0;
      dec_mem_wr = 1'b0;
      dec_ill    = 1'b0;
      if (opcode == 6'h00) begin
         dec_dest = rd_idx;
         case (funct)
            6'h20, 6'h21: dec_cmd = CMD_ADD;
            6'h22, 6'h23: dec_cmd = CMD_SUB;
            6'h24:        dec_cmd = CMD_AND;
            6'h25:        dec_cmd = CMD_OR;
            6'h26:        dec_cmd = CMD_XOR;
            6'h27:        dec_cmd = CMD_NOR;
            6'h00: begin dec_cmd = CMD_LEFT;   dec_a = rt_data; dec_b = shamt_z; end
            6'h02: begin dec_cmd = CMD_RIGHT;  dec_a = rt_data; dec_b = shamt_z; end
            6'h03: begin dec_cmd = CMD_SRIGHT; dec_a = rt_data; dec_b = shamt_z; end
            6'h04: begin dec_cmd = CMD_LEFT;   dec_a = rt_data; dec_b = {27'b0, rs_data[4:0]}; end
            6'h06: begin dec_cmd = CMD_RIGHT;  dec_a = rt_data; dec_b = {27'b0, rs_data[4:0]}; end
            6'h07: begin dec_cmd = CMD_SRIGHT; dec_a = rt_data; dec_b = {27'b0, rs_data[4:0]}; end
            default: dec_ill = 1'b1;
         endcase
      end else begin
         case (opcode)
            6'h08, 6'h09: dec_b = imm_s;
            6'h0C: begin dec_cmd = CMD_AND; dec_b = imm_z; end
            6'h0D: begin dec_cmd = CMD_OR;  dec_b = imm_z; end
            6'h0E: begin dec_cmd = CMD_XOR; dec_b = imm_z; end
            6'h0F: begin dec_cmd = CMD_LEFT; dec_a = imm_z; dec_b = 32'd16; end
            6'h23: begin dec_b = imm_s; dec_mem_rd = 1'b1; end
            6'h2B: begin dec_b = imm_s; dec_we = 1'b0; dec_mem_wr = 1'b1; end
            6'h04, 6'h05: begin dec_cmd = CMD_SUB; dec_we = 1'b0; dec_dest = 5'd0; end
            default: dec_ill = 1'b1;
         endcase
      end
      // Illegal words issue as an all-zero bubble carrying only the flag.
      if (dec_ill) begin
         dec_a      = '0;
         dec_b      = '0;
         dec_cmd    = CMD_ADD;
         dec_dest   = '0;
         dec_we     = 1'b0;
         dec_mem_rd = 1'b0;
         dec_mem_wr = 1'b0;
      end
      if (dec_dest == 5'd0) dec_we = 1'b0;
   end

   logic        valid_q, valid_d;
   logic [31:0] a_q, b_q;
   logic [3:0]  cmd_q;
   logic [4:0]  dest_q;
   logic        we_q, mem_rd_q, mem_wr_q, ill_q;
   logic [7:0]  cnt_q, cnt_d;
   logic        load;

   assign in_ready = !valid_q || out_ready;
   assign load     = in_valid && in_ready && !flush;

   always_comb begin
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (load) begin
         valid_d = 1'b1;
         if (dec_ill && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else if (flush || out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         cmd_q    <= '0;
         dest_q   <= '0;
         we_q     <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         ill_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         if (load) begin
            a_q      <= dec_a;
            b_q      <= dec_b;
            cmd_q    <= dec_cmd;
            dest_q   <= dec_dest;
            we_q     <= dec_we;
            mem_rd_q <= dec_mem_rd;
            mem_wr_q <= dec_mem_wr;
            ill_q    <= dec_ill;
         end
      end
   end

   assign out_valid     = valid_q;
   assign out_a         = a_q;
   assign out_b         = b_q;
   assign out_cmd       = cmd_q;
   assign out_dest      = dest_q;
   assign out_we        = we_q;
   assign out_mem_rd    = mem_rd_q;
   assign out_mem_wr    = mem_wr_q;
   assign out_illegal   = ill_q;
   assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic, all checked
// against a behavioural decode/handshake model.
module tb_alu_issue_stage;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        instr, rs_data, rt_data;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out_a, out_b;
   logic [3:0]         out_cmd;
   logic [4:0]         out_dest;
   logic               out_we, out_mem_rd, out_mem_wr, out_illegal;
   logic [7:0]         illegal_count;

   alu_issue_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_cmd(out_cmd), .out_dest(out_dest), .out_we(out_we),
      .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_illegal(out_illegal), .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  cmd;
      logic [4:0]  dest;
      logic        we, rd, wr, ill;
   } entry_t;

   int     errors = 0;
   int     checks = 0;
   logic   m_valid = 1'b0;
   entry_t m_e = '0;
   int     m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic entry_t ref_dec(input logic [31:0] w, input logic [31:0] rs,
                                      input logic [31:0] rt);
      entry_t e;
      int op, fn;
      bit ok;
      logic [31:0] sx, zx, sh, rsh;
      op  = int'(w[31:26]);
      fn  = int'(w[5:0]);
      sx  = {{16{w[15]}}, w[15:0]};
      zx  = {16'h0, w[15:0]};
      sh  = 32'(w[10:6]);
      rsh = rs % 32;
      ok  = 1'b1;
      e   = '0;
      if (op == 0) begin
         e.dest = w[15:11];
         e.we   = 1'b1;
         case (fn)
            32, 33: begin e.cmd = 0; e.a = rs; e.b = rt; end
            34, 35: begin e.cmd = 2; e.a = rs; e.b = rt; end
            36:     begin e.cmd = 4; e.a = rs; e.b = rt; end
            37:     begin e.cmd = 5; e.a = rs; e.b = rt; end
            38:     begin e.cmd = 7; e.a = rs; e.b = rt; end
            39:     begin e.cmd = 6; e.a = rs; e.b = rt; end
            0:      begin e.cmd = 8;  e.a = rt; e.b = sh; end
            2:      begin e.cmd = 10; e.a = rt; e.b = sh; end
            3:      begin e.cmd = 9;  e.a = rt; e.b = sh; end
            4:      begin e.cmd = 8;  e.a = rt; e.b = rsh; end
            6:      begin e.cmd = 10; e.a = rt; e.b = rsh; end
            7:      begin e.cmd = 9;  e.a = rt; e.b = rsh; end
            default: ok = 1'b0;
         endcase
      end else begin
         e.dest = w[20:16];
         e.we   = 1'b1;
         e.a    = rs;
         case (op)
            8, 9:  begin e.cmd = 0; e.b = sx; end
            12:    begin e.cmd = 4; e.b = zx; end
            13:    begin e.cmd = 5; e.b = zx; end
            14:    begin e.cmd = 7; e.b = zx; end
            15:    begin e.cmd = 8; e.a = zx; e.b = 16; end
            35:    begin e.cmd = 0; e.b = sx; e.rd = 1'b1; end
            43:    begin e.cmd = 0; e.b = sx; e.we = 1'b0; e.wr = 1'b1; end
            4, 5:  begin e.cmd = 2; e.b = rt; e.we = 1'b0; e.dest = 0; end
            default: ok = 1'b0;
         endcase
      end
      if (!ok) begin
         e     = '0;
         e.ill = 1'b1;
      end
      if (e.dest == 0) e.we = 1'b0;
      return e;
   endfunction

   // One clock: check in_ready before the edge, advance the model, check outputs after it.
   task automatic cycle();
      entry_t d;
      #1 chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      @(posedge clk);
      d = ref_dec(instr, rs_data, rt_data);
      if (!rst) begin
         m_valid = 1'b0;
         m_e     = '0;
         m_cnt   = 0;
      end else if (in_valid && !flush && (!m_valid || out_ready)) begin
         m_valid = 1'b1;
         m_e     = d;
         if (d.ill && m_cnt < 255) m_cnt++;
      end else if (flush || (m_valid && out_ready)) begin
         m_valid = 1'b0;
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
      if (m_valid) begin
         chk("out_a", out_a, m_e.a);
         chk("out_b", out_b, m_e.b);
         chk("out_cmd", 32'(out_cmd), 32'(m_e.cmd));
         chk("out_dest", 32'(out_dest), 32'(m_e.dest));
         chk("out_we", 32'(out_we), 32'(m_e.we));
         chk("out_mem_rd", 32'(out_mem_rd), 32'(m_e.rd));
         chk("out_mem_wr", 32'(out_mem_wr), 32'(m_e.wr));
         chk("out_illegal", 32'(out_illegal), 32'(m_e.ill));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_a"}, out_a, 0);
      chk({tag, "_b"}, out_b, 0);
      chk({tag, "_flags"}, 32'({out_cmd, out_dest, out_we, out_mem_rd, out_mem_wr, out_illegal}), 0);
      chk({tag, "_count"}, 32'(illegal_count), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 1);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int r_funct[13] = '{32, 33, 34, 35, 36, 37, 38, 39, 0, 2, 3, 4, 6};
      int i_ops[12]   = '{8, 9, 12, 13, 14, 15, 35, 43, 4, 5, 63, 2};
      w = $urandom;
      case ($urandom_range(0, 3))
         0: ;
         1: begin w[31:26] = 6'h00; w[5:0] = 6'(r_funct[$urandom_range(0, 12)]); end
         2: w[31:26] = 6'(i_ops[$urandom_range(0, 11)]);
         default: w[31:26] = 6'h00;
      endcase
      if ($urandom_range(0, 7) == 0) w[15:11] = 5'd0;
      if ($urandom_range(0, 7) == 0) w[20:16] = 5'd0;
      return w;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
      flush = 1'b0; out_ready = 1'b1;
      cycle(); cycle();
      check_all_zero("reset");
      rst = 1'b1;

      // add $3,$1,$2 with rs=5, rt=-7
      in_valid = 1'b1; instr = 32'h00221820; rs_data = 32'd5; rt_data = -32'sd7;
      cycle();
      chk("add_a", out_a, 32'd5);
      chk("add_b", out_b, 32'hFFFFFFF9);
      chk("add_dest", 32'(out_dest), 3);
      chk("add_we", 32'(out_we), 1);

      // addi then ori into $4
      instr = 32'h2004FFFF; rs_data = 32'd0;
      cycle();
      chk("addi_b", out_b, 32'hFFFFFFFF);
      chk("addi_cmd", 32'(out_cmd), 0);
      instr = 32'h3404FFFF;
      cycle();
      chk("ori_b", out_b, 32'h0000FFFF);
      chk("ori_cmd", 32'(out_cmd), 5);

      // sra $2,$5,4 then stall for three cycles
      instr = 32'h00051103; rt_data = 32'h80000000;
      cycle();
      out_ready = 1'b0; instr = 32'h00221820; rs_data = 32'd1; rt_data = 32'd2;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_cmd", 32'(out_cmd), 9);
         chk("stall_a", out_a, 32'h80000000);
         chk("stall_b", out_b, 32'd4);
         chk("stall_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      cycle();
      chk("noбubble_valid", 32'(out_valid), 1);
      chk("nobubble_cmd", 32'(out_cmd), 0);

      // flush with a held entry and a new instruction offered
      out_ready = 1'b0;
      cycle();
      flush = 1'b1; instr = 32'hFC000000;
      cycle();
      chk("flush_valid", 32'(out_valid), 0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      chk("flush_noload", 32'(out_valid), 0);

      // 300 illegal words saturate the counter
      in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         instr = {6'h3F, 26'($urandom)};
         cycle();
      end
      chk("sat_count", 32'(illegal_count), 255);
      chk("sat_illegal", 32'(out_illegal), 1);

      // reset while stalled
      instr = 32'h00221820; cycle();
      out_ready = 1'b0; cycle();
      rst = 1'b0; cycle();
      check_all_zero("stall_reset");
      rst = 1'b1;

      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 9) == 0);
         rst       = ($urandom_range(0, 49) != 0);
         instr     = rand_instr();
         rs_data   = $urandom;
         rt_data   = $urandom;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
